// File: rtl/sram_burst_reader_pkg.sv
// Shared definitions for the SRAM burst reader: controller state encoding and
// the read-pipeline occupancy limit.
package sram_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Reads in flight plus words held in the buffer never exceed this.
  localparam int unsigned MAX_OUTSTANDING = 2;

endpackage

// File: rtl/sram_burst_reader_skid_buffer.sv
// Two-entry FIFO that decouples SRAM read returns from the consumer's ready,
// carrying a last-beat flag alongside each word.
module sram_burst_reader_skid_buffer #(
  parameter int nrOfDataBits = 32
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic                    i_push,
  input  logic [nrOfDataBits-1:0] i_push_data,
  input  logic                    i_push_last,
  input  logic                    i_pop,
  output logic [nrOfDataBits-1:0] o_data,
  output logic                    o_last,
  output logic                    o_valid,
  output logic [1:0]              o_count
);

  logic [nrOfDataBits-1:0] r_data [2];
  logic [1:0]              r_last;
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [1:0]              r_count;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
      end
      r_last   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_data[r_wr_ptr] <= i_push_data;
        r_last[r_wr_ptr] <= i_push_last;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: ;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_data[r_rd_ptr];
  assign o_last  = o_valid && r_last[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/sram_burst_reader.sv
// Streams a burst of consecutive (wrapping) words out of a synchronous SRAM
// with one-cycle read latency onto a valid/ready interface.
module sram_burst_reader
  import sram_burst_reader_pkg::*;
#(
  parameter int nrOfAddressBits = 5,
  parameter int nrOfDataBits    = 32
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic                       i_start,
  input  logic [nrOfAddressBits-1:0] i_start_address,
  input  logic [nrOfAddressBits:0]   i_burst_length,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [nrOfAddressBits-1:0] o_sram_read_address,
  input  logic [nrOfDataBits-1:0]    i_sram_read_data,
  output logic [nrOfDataBits-1:0]    o_data_out,
  output logic                       o_data_valid,
  input  logic                       i_data_ready,
  output logic                       o_data_last
);

  localparam logic [nrOfAddressBits:0]   LEN_ONE  = 1;
  localparam logic [nrOfAddressBits-1:0] ADDR_ONE = 1;

  state_t                       r_state;
  state_t                       w_state_next;
  logic [nrOfAddressBits-1:0]   r_addr;
  logic [nrOfAddressBits:0]     r_issue_left;
  logic                         r_outstanding;
  logic                         r_outstanding_last;
  logic                         r_done;

  logic                         w_accept;
  logic                         w_len_zero;
  logic                         w_issue;
  logic                         w_issue_last;
  logic                         w_done_next;
  logic                         w_pop;
  logic                         w_buf_valid;
  logic                         w_buf_last;
  logic [1:0]                   w_buf_count;
  logic [2:0]                   w_occupancy;

  assign w_accept     = (r_state == ST_IDLE) && i_start;
  assign w_len_zero   = (i_burst_length == '0);
  assign w_issue_last = (r_issue_left == LEN_ONE);
  assign w_pop        = w_buf_valid && i_data_ready;
  // A beat leaving this cycle frees its slot, which keeps one read per cycle.
  assign w_occupancy  = {1'b0, w_buf_count} + {2'b0, r_outstanding} - {2'b0, w_pop};

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = w_len_zero ? ST_DRAIN : ST_READ;
          w_done_next  = w_len_zero;
        end
      end
      ST_READ: begin
        w_issue = (w_occupancy < 3'(MAX_OUTSTANDING));
        if (w_issue && w_issue_last) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!r_outstanding && (w_buf_count == 2'd0)) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_pop && w_buf_last) begin
      w_done_next = 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_addr             <= '0;
      r_issue_left       <= '0;
      r_outstanding      <= 1'b0;
      r_outstanding_last <= 1'b0;
      r_done             <= 1'b0;
    end else begin
      r_done             <= w_done_next;
      r_outstanding      <= w_issue;
      r_outstanding_last <= w_issue && w_issue_last;
      if (w_accept && !w_len_zero) begin
        r_addr       <= i_start_address;
        r_issue_left <= i_burst_length;
      end else if (w_issue) begin
        r_issue_left <= r_issue_left - LEN_ONE;
        // The final address stays on the bus once the burst is fully issued.
        if (!w_issue_last) begin
          r_addr <= r_addr + ADDR_ONE;
        end
      end
    end
  end

  sram_burst_reader_skid_buffer #(
    .nrOfDataBits(nrOfDataBits)
  ) u_stream_skid_buffer (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_push      (r_outstanding),
    .i_push_data (i_sram_read_data),
    .i_push_last (r_outstanding_last),
    .i_pop       (w_pop),
    .o_data      (o_data_out),
    .o_last      (w_buf_last),
    .o_valid     (w_buf_valid),
    .o_count     (w_buf_count)
  );

  assign o_busy              = (r_state != ST_IDLE);
  assign o_done              = r_done;
  assign o_sram_read_address = r_addr;
  assign o_data_valid        = w_buf_valid;
  assign o_data_last         = w_buf_last;

endmodule

// File: tb/tb_sram_burst_reader.sv
// Scoreboard bench for sram_burst_reader: bursts are expanded into expected
// beats from a memory image, and a monitor compares every transferred beat.
module tb_sram_burst_reader;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   burst_len = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_rdata = '0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          data_ready = 1'b0;
  logic          data_last;

  always #5 clk = ~clk;

  sram_burst_reader #(
    .nrOfAddressBits(AW),
    .nrOfDataBits   (DW)
  ) dut (
    .i_clock            (clk),
    .i_reset_n          (rst_n),
    .i_start            (start),
    .i_start_address    (start_addr),
    .i_burst_length     (burst_len),
    .o_busy             (busy),
    .o_done             (done),
    .o_sram_read_address(sram_addr),
    .i_sram_read_data   (sram_rdata),
    .o_data_out         (data_out),
    .o_data_valid       (data_valid),
    .i_data_ready       (data_ready),
    .o_data_last        (data_last)
  );

  // Synchronous SRAM, one-cycle latency, registered read data.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) sram_rdata <= mem[sram_addr];

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            due;
  } beat_t;

  beat_t exp_q[$];
  int total = 0;
  int bad = 0;
  int beats_seen = 0;
  int zero_issued = 0;
  int zero_seen = 0;
  int ready_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Consumer ready: always high, the 1,0,0,1 pattern, or random.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       data_ready = 1'b1;
        1: begin
          data_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
          ph++;
        end
        default: data_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: reset values, done timing, stall stability, beat contents.
  initial begin
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic          last_xfer = 1'b0;
    logic          exp_done;
    beat_t         b;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset valid", data_valid, 0);
        check("reset last", data_last, 0);
        check("reset data", data_out, 0);
        check("reset addr", sram_addr, 0);
        prev_stall = 1'b0;
        last_xfer  = 1'b0;
      end else begin
        exp_done = last_xfer;
        if (zero_issued != zero_seen) begin
          exp_done = 1'b1;
          zero_seen++;
        end
        if (exp_done || done) check("done pulse", done, exp_done);
        last_xfer = 1'b0;
        if (prev_stall) begin
          check("stall valid", data_valid, 1);
          check("stall data", data_out, prev_data);
          check("stall last", data_last, prev_last);
        end
        if (data_valid) begin
          if (exp_q.size() == 0) begin
            check("beat with empty queue", data_valid, 0);
          end else if (data_ready) begin
            b = exp_q.pop_front();
            check("beat data", data_out, b.data);
            check("beat last", data_last, b.last);
            if (b.due >= 0) check("beat cycle", cycle, b.due);
            beats_seen++;
            last_xfer = b.last;
          end
        end
        prev_stall = data_valid && !data_ready;
        prev_data  = data_out;
        prev_last  = data_last;
      end
    end
  end

  // Called #1 after a rising edge with busy low; the start lands on the next edge.
  task automatic issue_start(input logic [AW-1:0] a, input int len, input bit timed);
    start      = 1'b1;
    start_addr = a;
    burst_len  = len[AW:0];
    for (int i = 0; i < len; i++) begin
      exp_q.push_back('{mem[(int'(a) + i) % DEPTH], (i == len - 1), timed ? cycle + 3 + i : -1});
    end
    $display("burst start=%0d len=%0d ready_mode=%0d", a, len, ready_mode);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (len == 0) zero_issued++;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, " completes in time"}, (n < 2000), 1);
    check({name, " queue drained"}, exp_q.size(), 0);
  endtask

  task automatic run_burst(input string name, input logic [AW-1:0] a, input int len, input int mode);
    ready_mode = mode;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    issue_start(a, len, mode == 0);
    wait_idle(name);
    if (len > 0) check({name, " address held"}, sram_addr, (int'(a) + len - 1) % DEPTH);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = ($urandom() & 32'hFFFF_FFE0) | i;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_burst("basic", 5'd3, 4, 0);
    run_burst("wrap", 5'd30, 5, 0);
    run_burst("stall pattern", 5'($urandom_range(0, DEPTH - 1)), 8, 1);
    run_burst("zero length", 5'd9, 0, 0);
    run_burst("full wrap", 5'd17, DEPTH, 2);
    run_burst("single", 5'd31, 1, 0);

    // Reset after the second beat of a ten-word burst.
    ready_mode = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    base = beats_seen;
    issue_start(5'd12, 10, 1'b1);
    n = 0;
    while (beats_seen < base + 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("two beats before reset", (n < 100), 1);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("no done after reset", done, 0);
    rst_n = 1'b1;
    issue_start(5'd20, 3, 1'b1);
    wait_idle("after reset");

    // Starts while busy are ignored.
    ready_mode = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    issue_start(5'd10, 6, 1'b1);
    start      = 1'b1;
    start_addr = 5'd0;
    burst_len  = 6'd3;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_idle("start while busy");

    for (int t = 0; t < 20; t++) begin
      run_burst("random", 5'($urandom_range(0, DEPTH - 1)), $urandom_range(0, DEPTH),
                $urandom_range(0, 2));
    end

    repeat (5) @(posedge clk);
    #1;
    check("final queue empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_burst_reader.md
SRAM_BURST_READER -- requirements
Module: sramBurstReader

Interface
REQ-001 SHALL have parameter nrOfAddressBits, default 5, SRAM address width.
REQ-002 SHALL have parameter nrOfDataBits, default 32, SRAM and stream data width.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetN  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  burst request, accepted only when busy=0.
REQ-006 SHALL have port startAddress  input  nrOfAddressBits  first word address, sampled with an accepted start.
REQ-007 SHALL have port burstLength  input  nrOfAddressBits+1  word count (0..2^nrOfAddressBits), sampled with an accepted start.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the burst completes.
REQ-010 SHALL have port sramReadAddress  output  nrOfAddressBits  drives the read address of a synchronous SRAM.
REQ-011 SHALL have port sramReadData  input  nrOfDataBits  SRAM read data, valid exactly one cycle after the address is presented.
REQ-012 SHALL have port dataOut  output  nrOfDataBits  stream data.
REQ-013 SHALL have port dataValid  output  1  stream valid.
REQ-014 SHALL have port dataReady  input  1  stream ready from the consumer.
REQ-015 SHALL have port dataLast  output  1  high with the final beat of the burst.

Function
REQ-016 SHALL implement FSM states IDLE, READ and DRAIN.
REQ-017 SHALL transition IDLE->READ on start with burstLength>0, and IDLE->DRAIN on start with burstLength=0.
REQ-018 SHALL transition READ->DRAIN when the last address is issued, and DRAIN->IDLE when no word is outstanding and the buffer is empty.
REQ-019 SHALL count a beat as transferred only in a cycle where dataValid=1 and dataReady=1.
REQ-020 SHALL hold dataOut, dataValid and dataLast stable while dataValid=1 and dataReady=0.
REQ-021 SHALL issue a read only if outstanding reads plus buffered words is less than 2.
REQ-022 SHALL capture sramReadData in the cycle after each issued read, without needing to re-read.
REQ-023 SHALL present addresses startAddress, startAddress+1, ..., wrapping modulo 2^nrOfAddressBits.
REQ-024 SHALL sustain one beat per cycle with dataReady held high, giving a first-beat latency of 2 cycles after the accepted start.
REQ-025 SHALL deliver exactly burstLength beats, with dataLast asserted only on the final beat.
REQ-026 SHALL pulse done for one cycle after the last beat transfers.
REQ-027 SHALL, for burstLength=0, pulse done in the cycle after start and emit no beat.
REQ-028 SHALL ignore start while busy=1, leaving the burst in progress unaffected.
REQ-029 SHALL handle burstLength=2^nrOfAddressBits as a full wrap that reads every address exactly once.
REQ-030 SHALL hold sramReadAddress at its last value whenever no read is issued.

Reset
REQ-031 SHALL, while resetN=0, force state=IDLE, busy=0, done=0, dataValid=0, dataLast=0, dataOut=0, sramReadAddress=0, and clear all counters and buffer entries.
REQ-032 SHALL, on a reset mid-burst, abandon the burst with no further beats and no done pulse.
REQ-033 SHALL, after resetN deasserts, accept start from the first rising clock edge.

Structure
REQ-034 SHALL place the FSM state encoding and the maximum-outstanding constant (2) in a shared package.
REQ-035 SHALL implement the 2-entry buffer as one sub-module, streamSkidBuffer, parameterised by nrOfDataBits.
REQ-036 SHALL be verified against a behavioural synchronous SRAM with 1-cycle read latency and registered read data.

Verification
REQ-037 SHALL cover: startAddress=3, burstLength=4, dataReady=1 -> words 3,4,5,6 on consecutive cycles, dataLast on word 6, then a done pulse.
REQ-038 SHALL cover: startAddress=30, burstLength=5, nrOfAddressBits=5 -> words 30,31,0,1,2.
REQ-039 SHALL cover: burstLength=8 with dataReady toggling 1,0,0,1 repeatedly -> 8 beats in order, no loss, no duplicate, data stable while stalled.
REQ-040 SHALL cover: burstLength=0 -> done one cycle after start, dataValid never asserted.
REQ-041 SHALL cover: resetN pulled low after the 2nd beat of a 10-word burst -> all outputs 0, no done pulse; a new start then runs normally.
REQ-042 SHALL cover: start reasserted during a busy burst -> ignored, original burst of 6 words completes unchanged.
